// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - runs the layer start/done handshakes in order with a watchdog, abort and run-cycle count
module layer_sequencer #(
  parameter int NUM_LAYERS     = 6,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int SETTLE         = 2,
  parameter int CNT_W          = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  output logic [NUM_LAYERS-1:0]         layer_start,
  input  logic [NUM_LAYERS-1:0]         layer_done,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(NUM_LAYERS)-1:0] err_layer,
  output logic [$clog2(NUM_LAYERS)-1:0] cur_layer,
  output logic [CNT_W-1:0]              perf_cycles
);
  localparam int IW = $clog2(NUM_LAYERS);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_RUN, S_RELEASE, S_NEXT, S_FINISH, S_WAIT_START_LOW, S_DRAIN, S_ERROR
  } state_t;

  state_t              r_state, w_next_state;
  logic [IW-1:0]       r_idx, w_next_idx;
  logic [TW-1:0]       r_timer, w_next_timer;
  logic [SW-1:0]       r_settle, w_next_settle;
  logic [CNT_W-1:0]    r_run_cnt, w_next_run;
  logic [NUM_LAYERS-1:0] r_layer_start, w_next_start;
  logic                r_busy, w_next_busy;
  logic                r_done;
  logic                r_error;
  logic [IW-1:0]       r_err_layer;
  logic [CNT_W-1:0]    r_perf;
  logic                w_set_err, w_clr_err;
  logic                w_cur_done;

  assign w_cur_done = layer_done[r_idx];

  always_comb begin
    w_next_state  = r_state;
    w_next_idx    = r_idx;
    w_next_timer  = r_timer;
    w_next_settle = r_settle;
    w_next_run    = r_run_cnt;
    w_set_err     = 1'b0;
    w_clr_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_ARM;
          w_next_idx   = '0;
          w_next_timer = '0;
          w_next_run   = '0;
        end
      end
      S_ARM, S_RUN: begin
        w_next_timer = r_timer + TW'(1);
        w_next_run   = r_run_cnt + CNT_W'(1);
        // Priority: abort, then a real completion, then the watchdog.
        if (abort) begin
          w_next_state  = S_DRAIN;
          w_next_settle = '0;
        end else if (r_state == S_RUN && w_cur_done) begin
          w_next_state  = S_RELEASE;
          w_next_settle = '0;
        end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          w_next_state = S_ERROR;
          w_set_err    = 1'b1;
        end else if (r_state == S_ARM && !w_cur_done) begin
          w_next_state = S_RUN;
        end
      end
      S_RELEASE: begin
        w_next_run = r_run_cnt + CNT_W'(1);
        if (abort) begin
          w_next_state  = S_DRAIN;
          w_next_settle = '0;
        end else if (r_settle == SW'(SETTLE - 1)) begin
          w_next_state = (r_idx == IW'(NUM_LAYERS - 1)) ? S_FINISH : S_NEXT;
        end else begin
          w_next_settle = r_settle + SW'(1);
        end
      end
      S_NEXT: begin
        w_next_run = r_run_cnt + CNT_W'(1);
        if (abort) begin
          w_next_state  = S_DRAIN;
          w_next_settle = '0;
        end else begin
          w_next_state = S_ARM;
          w_next_idx   = r_idx + IW'(1);
          w_next_timer = '0;
        end
      end
      S_FINISH: w_next_state = S_WAIT_START_LOW;
      S_WAIT_START_LOW: begin
        if (!start) begin
          w_next_state = S_IDLE;
          w_next_idx   = '0;
        end
      end
      S_DRAIN: begin
        if (r_settle == SW'(SETTLE - 1)) w_next_state = S_WAIT_START_LOW;
        else                             w_next_settle = r_settle + SW'(1);
      end
      S_ERROR: begin
        if (abort) begin
          w_next_state = S_WAIT_START_LOW;
          w_clr_err    = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_next_start = '0;
    if (w_next_state == S_ARM || w_next_state == S_RUN) w_next_start[w_next_idx] = 1'b1;
    w_next_busy = !(w_next_state == S_IDLE || w_next_state == S_WAIT_START_LOW ||
                    w_next_state == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_timer       <= '0;
      r_settle      <= '0;
      r_run_cnt     <= '0;
      r_layer_start <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_err_layer   <= '0;
      r_perf        <= '0;
    end else begin
      r_state       <= w_next_state;
      r_idx         <= w_next_idx;
      r_timer       <= w_next_timer;
      r_settle      <= w_next_settle;
      r_run_cnt     <= w_next_run;
      r_layer_start <= w_next_start;
      r_busy        <= w_next_busy;
      r_done        <= (w_next_state == S_FINISH);
      if (w_set_err) begin
        r_error     <= 1'b1;
        r_err_layer <= r_idx;
      end else if (w_clr_err) begin
        r_error     <= 1'b0;
      end
      if (w_next_state == S_FINISH) r_perf <= w_next_run;
    end
  end

  assign layer_start = r_layer_start;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign err_layer   = r_err_layer;
  assign cur_layer   = r_idx;
  assign perf_cycles = r_perf;
endmodule
